// File: rtl/rc5_pkg.sv
// Shared RC5 datapath types: word width, rotate-amount width and their typedefs.
package rc5_pkg;

    localparam int unsigned WORD_W  = 16;
    localparam int unsigned SHAMT_W = $clog2(WORD_W);

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [SHAMT_W-1:0] shamt_t;

endpackage

// File: rtl/rc5_rotl_barrel.sv
// Combinational log2(W)-stage barrel rotator (left; right as well when ROTL_ROTR_EN is defined).
module rc5_rotl_barrel
    import rc5_pkg::*;
#(
    parameter int unsigned W = WORD_W
) (
`ifdef ROTL_ROTR_EN
    input  logic                 dir_i,
`endif
    input  logic [W-1:0]         data_i,
    input  logic [$clog2(W)-1:0] amt_i,
    output logic [W-1:0]         data_o
);

    localparam int unsigned SHAMT_W = $clog2(W);

    logic [SHAMT_W-1:0] amt;
    logic [W-1:0]       stage [SHAMT_W+1];

`ifdef ROTL_ROTR_EN
    // Rotate right by k is rotate left by (W - k) mod W, i.e. the two's complement of k.
    always_comb begin
        amt = amt_i;
        if (dir_i) begin
            amt = ~amt_i + SHAMT_W'(1);
        end
    end
`else
    assign amt = amt_i;
`endif

    assign stage[0] = data_i;

    for (genvar j = 0; j < SHAMT_W; j++) begin : g_stage
        localparam int unsigned S = 2 ** j;
        assign stage[j+1] = amt[j] ? {stage[j][W-1-S:0], stage[j][W-1:W-S]} : stage[j];
    end

    assign data_o = stage[SHAMT_W];

endmodule

// File: rtl/rc5_rotl.sv
// RC5 data-dependent rotate with one registered, valid-tagged output stage.
// Define ROTL_ROTR_EN to add dir_i and rotate-right support.
module rc5_rotl
    import rc5_pkg::*;
#(
    parameter int unsigned W = WORD_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         valid_i,
`ifdef ROTL_ROTR_EN
    input  logic         dir_i,
`endif
    input  logic [W-1:0] data_i,
    input  logic [W-1:0] n_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    localparam int unsigned SHAMT_W = $clog2(W);

    logic [W-1:0] rot;
    logic [W-1:0] data_d, data_q;
    logic         valid_d, valid_q;

    rc5_rotl_barrel #(
        .W (W)
    ) u_barrel (
`ifdef ROTL_ROTR_EN
        .dir_i  (dir_i),
`endif
        .data_i (data_i),
        .amt_i  (n_i[SHAMT_W-1:0]),
        .data_o (rot)
    );

    // Data register only loads on valid cycles so idle cycles do not toggle data_o.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_i;
        if (valid_i) begin
            data_d = rot;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_rc5_rotl.sv
// Scoreboard bench for rc5_rotl: driver queues expected words, negedge monitor checks them.
module tb_rc5_rotl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        dir_i = 1'b0;
    logic [15:0] data_i = '0;
    logic [15:0] n_i = '0;
    logic        valid_o;
    logic [15:0] data_o;

    int unsigned total = 0;
    int unsigned bad = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_exp = '0;
    bit          mon_en = 1'b0;

    always #5 clk_i = ~clk_i;

    rc5_rotl #(
        .W (16)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
`ifdef ROTL_ROTR_EN
        .dir_i   (dir_i),
`endif
        .data_i  (data_i),
        .n_i     (n_i),
        .valid_o (valid_o),
        .data_o  (data_o)
    );

    function automatic logic [15:0] ref_rotl(input logic [15:0] d, input logic [15:0] n);
        logic [31:0] t;
        t = {d, d} << n[3:0];
        return t[31:16];
    endfunction

    function automatic logic [15:0] ref_rotr(input logic [15:0] d, input logic [15:0] n);
        logic [31:0] t;
        t = {d, d} >> n[3:0];
        return t[15:0];
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic issue(input logic [15:0] d, input logic [15:0] n, input bit dir,
                         input logic [15:0] exp);
        valid_i = 1'b1;
        data_i  = d;
        n_i     = n;
        dir_i   = dir;
        exp_q.push_back(exp);
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            valid_i = 1'b0;
            data_i  = 16'($urandom);
            n_i     = 16'($urandom);
            @(posedge clk_i);
            #1;
        end
    endtask

    // Monitor: pops on every valid output, otherwise checks data_o holds the last result.
    always @(negedge clk_i) begin
        if (mon_en) begin
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious: got valid data %h expected no output", data_o);
                end else begin
                    last_exp = exp_q.pop_front();
                    check("result", data_o, last_exp);
                end
            end else begin
                check("hold", data_o, last_exp);
            end
        end
    end

    initial begin
        logic [15:0] d, n, r;

        #3;
        check("rst_valid", {15'd0, valid_o}, 16'd0);
        check("rst_data", data_o, 16'h0000);
        @(posedge clk_i);
        #4 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        mon_en = 1'b1;

        issue(16'h8001, 16'h0001, 1'b0, 16'h0003);
        issue(16'h1234, 16'h0000, 1'b0, 16'h1234);
        issue(16'h1234, 16'h0004, 1'b0, 16'h2341);
        issue(16'h1234, 16'h0008, 1'b0, 16'h3412);
        issue(16'h1234, 16'h000F, 1'b0, 16'h091A);
        issue(16'h8001, 16'h0011, 1'b0, 16'h0003);
        issue(16'h8001, 16'h0010, 1'b0, 16'h8001);
        issue(16'h8001, 16'hFFFF, 1'b0, 16'hC000);
        idle(3);

        issue(16'hA5A5, 16'h0001, 1'b0, 16'h4B4B);
        issue(16'h00FF, 16'h0004, 1'b0, 16'h0FF0);
        issue(16'hF000, 16'h0006, 1'b0, 16'h003C);
        idle(4);

        for (int i = 0; i < 40; i++) begin
            d = 16'($urandom);
            n = 16'($urandom);
            issue(d, n, 1'b0, ref_rotl(d, n));
            if (($urandom & 3) == 0) idle(1);
        end

`ifdef ROTL_ROTR_EN
        issue(16'h0003, 16'h0001, 1'b1, 16'h8001);
        issue(16'h1234, 16'h0004, 1'b1, 16'h4123);
        issue(16'h8001, 16'h0010, 1'b1, 16'h8001);
        for (int i = 0; i < 20; i++) begin
            d = 16'($urandom);
            n = 16'($urandom);
            r = ref_rotl(d, n);
            issue(d, n, 1'b0, r);
            issue(r, n, 1'b1, d);
            issue(d, n, 1'b1, ref_rotr(d, n));
        end
        dir_i = 1'b0;
`endif
        idle(3);

        // Reset while one result is on the output and another is in flight.
        mon_en  = 1'b0;
        valid_i = 1'b1;
        data_i  = 16'h1234;
        n_i     = 16'h0004;
        @(posedge clk_i);
        #1;
        check("pre_rst_valid", {15'd0, valid_o}, 16'd1);
        check("pre_rst_data", data_o, 16'h2341);
        data_i = 16'hFFFF;
        n_i    = 16'h0001;
        #3 rst_ni = 1'b0;
        #1;
        check("rst_async_valid", {15'd0, valid_o}, 16'd0);
        check("rst_async_data", data_o, 16'h0000);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        check("rst_held_data", data_o, 16'h0000);
        #3 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        @(posedge clk_i);
        #1;
        check("post_rst_valid", {15'd0, valid_o}, 16'd0);
        check("post_rst_data", data_o, 16'h0000);
        last_exp = 16'h0000;
        mon_en   = 1'b1;

        issue(16'h8001, 16'h0001, 1'b0, 16'h0003);
        idle(3);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending results expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
